// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with blanking gap and frame-aligned updates.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).

module seg_decode (
  input  logic [3:0] code,
  output logic [6:0] seg
);
  // {g,f,e,d,c,b,a}, active low; non-BCD codes render as a dash
  always_comb begin
    case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0011000;
      default: seg = 7'b0111111;
    endcase
  end
endmodule

module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);
  localparam int CW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = 7'h7F;

  typedef enum logic {BLANK, SHOW} state_t;

  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  state_t                  state, state_nxt;
  logic [4*NUM_DIGITS-1:0] active, active_nxt, pending;
  logic                    pending_full;
  logic                    cnt_wrap, boundary, take;
  logic [3:0]              digit_nxt;
  logic [6:0]              seg_dec;
  logic                    lz_hit;

  assign data_ready = ~pending_full;
  assign take       = data_valid & ~pending_full;
  assign cnt_wrap   = (cnt == CNT_LAST);
  assign boundary   = cnt_wrap & (idx == IDX_LAST);

  // Outputs are registered from next-cycle counter values so they line up with cnt/idx.
  always_comb begin
    cnt_nxt    = cnt_wrap ? '0 : cnt + CW'(1);
    idx_nxt    = idx;
    if (cnt_wrap) idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    state_nxt  = state;
    if (cnt_wrap)                   state_nxt = BLANK;
    else if (cnt_nxt == CNT_SHOW)   state_nxt = SHOW;
    active_nxt = (boundary && pending_full) ? pending : active;
  end

  assign digit_nxt = active_nxt[4*idx_nxt +: 4];

  seg_decode u_dec (.code(digit_nxt), .seg(seg_dec));

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic hz;
    hz      = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hz         = hz & (active_nxt[4*i +: 4] == 4'h0);
      lz_mask[i] = hz;
    end
  end
  assign lz_hit = lz_mask[idx_nxt];
`else
  assign lz_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      state        <= BLANK;
      active       <= {NUM_DIGITS{4'hF}};
      pending      <= '0;
      pending_full <= 1'b0;
      segments     <= SEG_OFF;
      digit_en     <= '1;
      frame_tick   <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      state      <= state_nxt;
      active     <= active_nxt;
      frame_tick <= boundary;
      // A full pending slot blocks capture, so release and capture never collide.
      if (boundary && pending_full) begin
        pending_full <= 1'b0;
      end else if (take) begin
        pending      <= data_in;
        pending_full <= 1'b1;
      end
      if (state_nxt == SHOW) begin
        segments <= lz_hit ? SEG_OFF : seg_dec;
        digit_en <= ~(NUM_DIGITS'(1) << idx_nxt);
      end else begin
        segments <= SEG_OFF;
        digit_en <= '1;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at NUM_DIGITS=4, DIV=8, BLANK_CYCLES=2 (32-cycle frames).
module tb_seven_seg_scanner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int vec  = 0;
  int errs = 0;
  int tcyc = 0;
  logic [15:0] m_act, m_pend;
  bit          m_full;

  seven_seg_scanner #(.NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .segments(segments), .digit_en(digit_en), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Advance one clock; tracks frame position and acts as the producer (drops valid once taken).
  task automatic step();
    bit acc, bnd;
    bnd = (tcyc % 32 == 31);
    acc = data_valid && !m_full;
    @(posedge clk); #1;
    tcyc++;
    if (bnd && m_full) begin m_act = m_pend; m_full = 0; end
    if (acc) begin m_pend = data_in; m_full = 1; data_valid = 1'b0; end
  endtask

  task automatic to_pos(input int i, input int c);
    int tgt;
    tgt = i * 8 + c;
    do step(); while (tcyc % 32 != tgt);
  endtask

  task automatic offer(input logic [15:0] v);
    data_in    = v;
    data_valid = 1'b1;
  endtask

  task automatic wait_active(input logic [15:0] v);
    int n;
    n = 0;
    while (m_act !== v && n < 200) begin step(); n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_valid = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (segments !== 7'h7F) begin errs++; $display("FAIL reset_seg got %b want %b", segments, 7'h7F); end
    vec++; if (digit_en !== 4'hF) begin errs++; $display("FAIL reset_en got %b want %b", digit_en, 4'hF); end
    vec++; if (data_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", data_ready); end
    vec++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    rst_n = 1'b1; tcyc = 0; m_act = 16'hFFFF; m_full = 0;
    step();
    vec++; if (segments !== 7'h7F || digit_en !== 4'hF) begin errs++; $display("FAIL rel_blank got %b/%b want 1111111/1111", segments, digit_en); end
    vec++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL rel_tick got %b want 0", frame_tick); end
    step();
    vec++; if (segments !== 7'b0111111 || digit_en !== 4'b1110) begin errs++; $display("FAIL rel_dash got %b/%b want 0111111/1110", segments, digit_en); end
  endtask

  task automatic test_load();
    int ft;
    while (tcyc < 10) step();
    offer(16'h1234);
    step();
    vec++; if (data_ready !== 1'b0) begin errs++; $display("FAIL load_ready got %b want 0", data_ready); end
    while (tcyc < 26) step();
    vec++; if (segments !== 7'b0111111 || digit_en !== 4'b0111) begin errs++; $display("FAIL load_no_tear got %b/%b want 0111111/0111", segments, digit_en); end
    while (tcyc < 31) step();
    vec++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL load_tick_pre got %b want 0", frame_tick); end
    step();
    vec++; if (frame_tick !== 1'b1 || data_ready !== 1'b1) begin errs++; $display("FAIL load_boundary got tick=%b rdy=%b want 1/1", frame_tick, data_ready); end
    while (tcyc < 34) step();
    vec++; if (segments !== 7'b0011001 || digit_en !== 4'b1110) begin errs++; $display("FAIL load_d0 got %b/%b want 0011001/1110", segments, digit_en); end
    while (tcyc < 58) step();
    vec++; if (segments !== 7'b1111001 || digit_en !== 4'b0111) begin errs++; $display("FAIL load_d3 got %b/%b want 1111001/0111", segments, digit_en); end
    ft = 0;
    repeat (64) begin step(); if (frame_tick === 1'b1) ft++; end
    vec++; if (ft != 2) begin errs++; $display("FAIL tick_rate got %0d want 2", ft); end
  endtask

  task automatic test_back_to_back();
    to_pos(1, 3);
    offer(16'h1111);
    step();
    offer(16'h5678);
    vec++; if (data_ready !== 1'b0) begin errs++; $display("FAIL hold_ready0 got %b want 0", data_ready); end
    to_pos(3, 7);
    vec++; if (data_ready !== 1'b0) begin errs++; $display("FAIL hold_ready1 got %b want 0", data_ready); end
    step();
    vec++; if (data_ready !== 1'b1) begin errs++; $display("FAIL hold_freed got %b want 1", data_ready); end
    step();
    vec++; if (data_ready !== 1'b0) begin errs++; $display("FAIL hold_taken got %b want 0", data_ready); end
    to_pos(1, 3);
    vec++; if (segments !== 7'b1111001 || digit_en !== 4'b1101) begin errs++; $display("FAIL hold_old_d1 got %b/%b want 1111001/1101", segments, digit_en); end
    to_pos(3, 4);
    vec++; if (segments !== 7'b1111001 || digit_en !== 4'b0111) begin errs++; $display("FAIL hold_old_d3 got %b/%b want 1111001/0111", segments, digit_en); end
    to_pos(1, 3);
    vec++; if (segments !== 7'b1111000 || digit_en !== 4'b1101) begin errs++; $display("FAIL hold_new_d1 got %b/%b want 1111000/1101", segments, digit_en); end
    to_pos(3, 4);
    vec++; if (segments !== 7'b0010010 || digit_en !== 4'b0111) begin errs++; $display("FAIL hold_new_d3 got %b/%b want 0010010/0111", segments, digit_en); end
  endtask

  task automatic test_dash_sweep();
    logic [6:0] tbl [4];
    int c, i;
    tbl = '{7'b0111111, 7'b1000000, 7'b0011000, 7'b0111111};
    offer(16'hB90F);
    wait_active(16'hB90F);
    for (int k = 0; k < 32; k++) begin
      if (k > 0) step();
      c = tcyc % 8; i = (tcyc / 8) % 4;
      vec++;
      if (c < 2) begin
        if (segments !== 7'h7F || digit_en !== 4'hF) begin errs++; $display("FAIL sweep_blank i=%0d c=%0d got %b/%b want 1111111/1111", i, c, segments, digit_en); end
      end else begin
        if (segments !== tbl[i] || digit_en !== ~(4'b0001 << i)) begin errs++; $display("FAIL sweep_show i=%0d c=%0d got %b/%b want %b/%b", i, c, segments, digit_en, tbl[i], ~(4'b0001 << i)); end
      end
      vec++;
      if (frame_tick !== (k == 0)) begin errs++; $display("FAIL sweep_tick k=%0d got %b", k, frame_tick); end
    end
  endtask

  task automatic test_reset_mid();
    offer(16'h2222);
    to_pos(2, 5);
    data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vec++; if (segments !== 7'h7F || digit_en !== 4'hF) begin errs++; $display("FAIL mid_rst_out got %b/%b want 1111111/1111", segments, digit_en); end
    vec++; if (data_ready !== 1'b1 || frame_tick !== 1'b0) begin errs++; $display("FAIL mid_rst_hs got rdy=%b tick=%b want 1/0", data_ready, frame_tick); end
    #2;
    rst_n = 1'b1; tcyc = 0; m_act = 16'hFFFF; m_full = 0;
    step(); step();
    vec++; if (segments !== 7'b0111111 || digit_en !== 4'b1110) begin errs++; $display("FAIL mid_rst_dash got %b/%b want 0111111/1110", segments, digit_en); end
    to_pos(0, 2);
    vec++; if (segments !== 7'b0111111 || data_ready !== 1'b1) begin errs++; $display("FAIL mid_rst_discard got %b rdy=%b want 0111111/1", segments, data_ready); end
  endtask

  task automatic test_leading_zero();
    logic [6:0] z;
`ifdef LEADING_ZERO_BLANK_EN
    z = 7'h7F;
`else
    z = 7'b1000000;
`endif
    offer(16'h0045);
    wait_active(16'h0045);
    to_pos(3, 2);
    vec++; if (segments !== z || digit_en !== 4'b0111) begin errs++; $display("FAIL lz45_d3 got %b/%b want %b/0111", segments, digit_en, z); end
    to_pos(2, 2);
    vec++; if (segments !== z || digit_en !== 4'b1011) begin errs++; $display("FAIL lz45_d2 got %b/%b want %b/1011", segments, digit_en, z); end
    to_pos(1, 2);
    vec++; if (segments !== 7'b0011001 || digit_en !== 4'b1101) begin errs++; $display("FAIL lz45_d1 got %b/%b want 0011001/1101", segments, digit_en); end
    to_pos(0, 2);
    vec++; if (segments !== 7'b0010010 || digit_en !== 4'b1110) begin errs++; $display("FAIL lz45_d0 got %b/%b want 0010010/1110", segments, digit_en); end
    offer(16'h0000);
    wait_active(16'h0000);
    to_pos(0, 3);
    vec++; if (segments !== 7'b1000000 || digit_en !== 4'b1110) begin errs++; $display("FAIL lz0_d0 got %b/%b want 1000000/1110", segments, digit_en); end
    to_pos(1, 3);
    vec++; if (segments !== z || digit_en !== 4'b1101) begin errs++; $display("FAIL lz0_d1 got %b/%b want %b/1101", segments, digit_en, z); end
    to_pos(3, 7);
    vec++; if (segments !== z || digit_en !== 4'b0111) begin errs++; $display("FAIL lz0_d3 got %b/%b want %b/0111", segments, digit_en, z); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_dash_sweep();
    test_reset_mid();
    test_leading_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
